bit_unpacker: RTL and testbench
===============================

// Module: bit_unpacker
// PURPOSE
// Decoder-side counterpart of the encoder's output packer. Accepts a packed stream of DATA_W-bit
// words, MSB first, and keeps them in a 2*DATA_W-bit window. It presents the top DATA_W window
// bits to the downstream symbol decoder, which consumes a variable number of bits (0..DATA_W)
// per handshake. Sits between the decoder input FIFO and the ZRLE/BPC symbol decoders.
// PARAMETERS
// DATA_W  8  word width; buffer is 2*DATA_W bits, fill counter is $clog2(2*DATA_W+1) bits
// PORTS
// clk_i    in   1                         clock, rising edge
// rst_i    in   1                         asynchronous reset, active-high
// clr_i    in   1                         synchronous clear: discards all buffered bits, returns to EMPTY
// data_i   in   DATA_W                    packed input word, first bit at MSB
// last_i   in   1                         data_i is the final word of the stream
// vld_i    in   1                         input word valid
// rdy_o    out  1                         input word accepted when vld_i && rdy_o
// data_o   out  DATA_W                    window = buffer[2*DATA_W-1 -: DATA_W]; next unread bit at MSB
// fill_o   out  $clog2(2*DATA_W+1)        number of valid buffered bits
// len_i    in   $clog2(DATA_W+1)          bits consumed on an output handshake (0..DATA_W)
// vld_o    out  1                         window valid
// rdy_i    in   1                         consumer takes len_i bits when vld_o && rdy_i
// last_o   out  1                         window holds every remaining bit of the stream
// idle_o   out  1                         FSM in EMPTY
// BEHAVIOUR
// - Reset (async, rst_i=1): buffer=0, fill=0, state EMPTY, last_seen=0. Resulting outputs:
//   rdy_o=1, vld_o=0, last_o=0, idle_o=1, data_o=0, fill_o=0. Reset mid-stream drops all data.
// - All outputs are decoded from registers only; there are no combinational in->out paths.
// - rdy_o = (fill_q <= DATA_W) && !last_seen_q.
// - vld_o = (fill_q >= DATA_W) || (last_seen_q && fill_q > 0).
// - last_o = vld_o && last_seen_q && (fill_q <= DATA_W).
// - Consumption: c = (vld_o && rdy_i) ? min(len_i, fill_q) : 0. len_i > fill_q happens only in DRAIN.
//   It is clamped, and a warning assertion fires if len_i > DATA_W.
// - Every cycle: buf_d = buf_q << c; fill_d = fill_q - c.
// - On load (vld_i && rdy_o): buf_d |= {data_i, DATA_W'b0} >> (fill_q - c); fill_d += DATA_W.
//   Load and consume in the same cycle are legal and use the pre-shift fill (fill_q - c).
// - Zero-fill invariant: bits below fill_q are always 0. Shifts insert zeros and are never
//   arithmetic. Fill never exceeds 2*DATA_W.
// - Latency: a word accepted in cycle n is visible on data_o/fill_o in cycle n+1.
// - FSM states:
//   EMPTY : fill=0, idle_o=1. Load -> STREAM, or -> DRAIN if last_i.
//   STREAM: load/consume as above. Load with last_i -> DRAIN (sets last_seen).
//           fill_d=0 without a load -> EMPTY.
//   DRAIN : no loads (rdy_o=0). Consumption continues. When fill_d=0 -> EMPTY, clearing last_seen.
// - clr_i has priority over load/consume: next cycle buf=0, fill=0, last_seen=0, EMPTY.
// - A vld_i && last_i word arriving in EMPTY is a complete one-word stream.
// - Trailing zero padding in the final word is delivered as ordinary bits; the consumer
//   terminates on last_o.
// TESTING (DATA_W=8)
// T1 load 0xA5 -> next cycle data_o=0xA5, fill_o=8, vld_o=1, rdy_o=1; then consume len 3 while
//    loading 0x3C -> data_o=0x29, fill_o=13.
// T2 fill_o=16, hold vld_i with 0x77 -> rdy_o=0, word not taken; consume len 8 -> fill_o=8;
//    0x77 then loads -> fill_o=16.
// T3 rdy_i=1 with len_i=0 for 5 cycles -> buffer, data_o and fill_o unchanged.
// T4 EMPTY, load 0x8C with last_i -> DRAIN; consume 5 -> data_o=0x80, fill_o=3, vld_o=1,
//    last_o=1, rdy_o=0; consume len 8 -> clamps to 3, next cycle idle_o=1, vld_o=0, rdy_o=1.
// T5 fill_o=13, pulse rst_i asynchronously mid-cycle -> immediately fill_o=0, vld_o=0, rdy_o=1,
//    idle_o=1; next word 0x5A -> data_o=0x5A.
// T6 fill_o=12 in DRAIN, assert clr_i with vld_o&&rdy_i, len 4 -> next cycle EMPTY, fill_o=0,
//    last_o=0; random 10k-word stream vs bit-queue model -> zero mismatches.

Source files
------------

// File: rtl/bit_unpacker.sv
// Bit unpacker: buffers MSB-first DATA_W-bit words in a 2*DATA_W-bit window and hands the
// top DATA_W bits to a consumer that takes a variable number of bits per handshake.
module bit_unpacker #(
  parameter int DATA_W = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic [DATA_W-1:0]                data_i,
  input  logic                             last_i,
  input  logic                             vld_i,
  output logic                             rdy_o,
  output logic [DATA_W-1:0]                data_o,
  output logic [$clog2(2*DATA_W+1)-1:0]    fill_o,
  input  logic [$clog2(DATA_W+1)-1:0]      len_i,
  output logic                             vld_o,
  input  logic                             rdy_i,
  output logic                             last_o,
  output logic                             idle_o
);
  localparam int BUF_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(2 * DATA_W + 1);
  localparam int LEN_W  = $clog2(DATA_W + 1);
  localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(DATA_W);

  typedef enum logic [1:0] {EMPTY, STREAM, DRAIN} state_t;

  state_t             state_q;
  logic [BUF_W-1:0]   buf_q;
  logic [BUF_W-1:0]   buf_d;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_d;
  logic [FILL_W-1:0]  take_n;
  logic [FILL_W-1:0]  rem_n;
  logic               last_seen_q;
  logic               take;
  logic               load;

  // In DRAIN the consumer may ask for more bits than remain; never take more than fill.
  function automatic logic [FILL_W-1:0] clamp_len(input logic [LEN_W-1:0]  len,
                                                  input logic [FILL_W-1:0] fill);
    logic [FILL_W-1:0] len_ext;
    len_ext = FILL_W'(len);
    return (len_ext > fill) ? fill : len_ext;
  endfunction

  assign vld_o  = (fill_q >= WORD_BITS) || (last_seen_q && (fill_q != '0));
  assign rdy_o  = (fill_q <= WORD_BITS) && !last_seen_q;
  assign last_o = vld_o && last_seen_q && (fill_q <= WORD_BITS);
  assign idle_o = (state_q == EMPTY);
  assign data_o = buf_q[BUF_W-1 -: DATA_W];
  assign fill_o = fill_q;

  assign take = vld_o && rdy_i;
  assign load = vld_i && rdy_o;

  // New word lands directly behind the bits that survive this cycle's consumption.
  always_comb begin
    take_n = take ? clamp_len(len_i, fill_q) : '0;
    rem_n  = fill_q - take_n;
    buf_d  = buf_q << take_n;
    fill_d = rem_n;
    if (load) begin
      buf_d  = buf_d | ({data_i, {DATA_W{1'b0}}} >> rem_n);
      fill_d = rem_n + WORD_BITS;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      buf_q       <= '0;
      fill_q      <= '0;
      last_seen_q <= 1'b0;
    end else if (clr_i) begin
      state_q     <= EMPTY;
      buf_q       <= '0;
      fill_q      <= '0;
      last_seen_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      case (state_q)
        EMPTY: begin
          if (load) begin
            state_q     <= last_i ? DRAIN : STREAM;
            last_seen_q <= last_i;
          end
        end
        STREAM: begin
          if (load && last_i) begin
            state_q     <= DRAIN;
            last_seen_q <= 1'b1;
          end else if (fill_d == '0) begin
            state_q <= EMPTY;
          end
        end
        DRAIN: begin
          if (fill_d == '0) begin
            state_q     <= EMPTY;
            last_seen_q <= 1'b0;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i && take)
      assert (len_i <= LEN_W'(DATA_W))
      else $warning("bit_unpacker: len_i=%0d exceeds DATA_W", len_i);
  end

endmodule

// File: tb/tb_bit_unpacker.sv
// Bench for bit_unpacker: directed vector table, async-reset sequence, and a long random
// stream compared against a bit-queue reference model.
module tb_bit_unpacker;
  localparam int DATA_W = 8;
  localparam int FILL_W = $clog2(2 * DATA_W + 1);
  localparam int LEN_W  = $clog2(DATA_W + 1);
  localparam int N_WORDS = 10000;
  localparam int MAX_CYC = 60000;

  logic               clk = 1'b0;
  logic               rst_i = 1'b0;
  logic               clr_i = 1'b0;
  logic [DATA_W-1:0]  data_i = '0;
  logic               last_i = 1'b0;
  logic               vld_i = 1'b0;
  logic               rdy_o;
  logic [DATA_W-1:0]  data_o;
  logic [FILL_W-1:0]  fill_o;
  logic [LEN_W-1:0]   len_i = '0;
  logic               vld_o;
  logic               rdy_i = 1'b0;
  logic               last_o;
  logic               idle_o;

  int total = 0;
  int bad   = 0;

  bit_unpacker #(.DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .data_i(data_i), .last_i(last_i),
    .vld_i(vld_i), .rdy_o(rdy_o), .data_o(data_o), .fill_o(fill_o), .len_i(len_i),
    .vld_o(vld_o), .rdy_i(rdy_i), .last_o(last_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              clr, vld, last, rdy;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] e_data;
    logic [FILL_W-1:0] e_fill;
    logic              e_vld, e_rdy, e_last, e_idle;
  } vec_t;

  vec_t tbl[$];
  bit   q[$];

  function automatic vec_t mk(input logic c, v, l, r, input logic [DATA_W-1:0] d,
                              input logic [LEN_W-1:0] n, input logic [DATA_W-1:0] ed,
                              input logic [FILL_W-1:0] ef, input logic ev, er, el, ei);
    vec_t t;
    t.clr = c; t.vld = v; t.last = l; t.rdy = r; t.data = d; t.len = n;
    t.e_data = ed; t.e_fill = ef; t.e_vld = ev; t.e_rdy = er; t.e_last = el; t.e_idle = ei;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, v, l, r, input logic [DATA_W-1:0] d,
                       input logic [LEN_W-1:0] n);
    clr_i = c; vld_i = v; last_i = l; rdy_i = r; data_i = d; len_i = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [DATA_W-1:0] ed,
                         input logic [FILL_W-1:0] ef, input logic ev, er, el, ei);
    chk({tag, ".data"}, int'(data_o), int'(ed));
    chk({tag, ".fill"}, int'(fill_o), int'(ef));
    chk({tag, ".vld"},  int'(vld_o),  int'(ev));
    chk({tag, ".rdy"},  int'(rdy_o),  int'(er));
    chk({tag, ".last"}, int'(last_o), int'(el));
    chk({tag, ".idle"}, int'(idle_o), int'(ei));
  endtask

  initial begin
    logic [DATA_W-1:0] exp_d;
    logic [DATA_W-1:0] rd;
    logic [LEN_W-1:0]  rn;
    logic              rv, rr, rl, m_vld, m_rdy, m_last;
    int                idx, cyc, rbad, cnt;

    // fill, consume while loading, back-pressure, zero-length takes, one-word stream, clear
    tbl.push_back(mk(0,1,0,0,8'hA5,0, 8'hA5, 8,1,1,0,0));
    tbl.push_back(mk(0,1,0,1,8'h3C,3, 8'h29,13,1,0,0,0));
    tbl.push_back(mk(0,0,0,1,8'h00,5, 8'h3C, 8,1,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h77,0, 8'h3C,16,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,8'h77,0, 8'h3C,16,1,0,0,0));
    tbl.push_back(mk(0,1,0,1,8'h77,8, 8'h77, 8,1,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h77,0, 8'h77,16,1,0,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,1,8'h00,0, 8'h77,16,1,0,0,0));
    tbl.push_back(mk(0,0,0,1,8'h00,8, 8'h77, 8,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,8'h00,8, 8'h00, 0,0,1,0,1));
    tbl.push_back(mk(0,1,1,0,8'h8C,0, 8'h8C, 8,1,0,1,0));
    tbl.push_back(mk(0,0,0,1,8'h00,5, 8'h80, 3,1,0,1,0));
    tbl.push_back(mk(0,0,0,1,8'h00,8, 8'h00, 0,0,1,0,1));
    tbl.push_back(mk(0,1,0,0,8'hA5,0, 8'hA5, 8,1,1,0,0));
    tbl.push_back(mk(0,1,1,1,8'h3C,4, 8'h53,12,1,0,0,0));
    tbl.push_back(mk(1,1,0,1,8'hC3,4, 8'h00, 0,0,1,0,1));

    #2 rst_i = 1'b1;
    #1 chk_all("reset", 8'h00, 0, 0, 1, 0, 1);
    step();
    step();
    rst_i = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].vld, tbl[i].last, tbl[i].rdy, tbl[i].data, tbl[i].len);
      step();
      chk_all($sformatf("row%0d", i), tbl[i].e_data, tbl[i].e_fill, tbl[i].e_vld,
              tbl[i].e_rdy, tbl[i].e_last, tbl[i].e_idle);
    end

    // asynchronous reset in the middle of a cycle with 13 bits buffered
    drive(0,1,0,0,8'hA5,0);
    step();
    drive(0,1,0,1,8'h3C,3);
    step();
    chk("arst.pre_fill", int'(fill_o), 13);
    drive(0,0,0,0,8'h00,0);
    #3 rst_i = 1'b1;
    #1 chk_all("arst", 8'h00, 0, 0, 1, 0, 1);
    #1 rst_i = 1'b0;
    drive(0,1,0,0,8'h5A,0);
    step();
    chk_all("arst.reload", 8'h5A, 8, 1, 1, 0, 0);
    drive(0,0,0,1,8'h00,8);
    step();
    chk("arst.drained", int'(idle_o), 1);

    // random stream against a bit-queue model
    q.delete();
    m_last = 1'b0;
    idx = 0; cyc = 0; rbad = 0;
    while (!(idx == N_WORDS && q.size() == 0) && cyc < MAX_CYC && rbad < 10) begin
      exp_d = '0;
      for (int i = 0; i < DATA_W; i++)
        if (i < q.size()) exp_d[DATA_W-1-i] = q[i];
      m_vld = (q.size() >= DATA_W) || (m_last && q.size() > 0);
      m_rdy = (q.size() <= DATA_W) && !m_last;
      cnt = bad;
      chk("rand.data", int'(data_o), int'(exp_d));
      chk("rand.fill", int'(fill_o), q.size());
      chk("rand.vld",  int'(vld_o),  int'(m_vld));
      chk("rand.rdy",  int'(rdy_o),  int'(m_rdy));
      chk("rand.last", int'(last_o), int'(m_vld && m_last && q.size() <= DATA_W));
      chk("rand.idle", int'(idle_o), int'(q.size() == 0));
      rbad += bad - cnt;

      rv = (idx < N_WORDS) && ($urandom_range(3) != 0);
      rd = DATA_W'($urandom);
      rl = (idx == N_WORDS - 1);
      rr = ($urandom_range(3) != 0);
      rn = ($urandom_range(4) == 0) ? LEN_W'($urandom_range(3)) : LEN_W'($urandom_range(8, 4));
      drive(0, rv, rl, rr, rd, rn);

      if (m_vld && rr) begin
        cnt = (int'(rn) > q.size()) ? q.size() : int'(rn);
        for (int k = 0; k < cnt; k++) void'(q.pop_front());
      end
      if (rv && m_rdy) begin
        for (int b = DATA_W - 1; b >= 0; b--) q.push_back(rd[b]);
        idx++;
        if (rl) m_last = 1'b1;
      end
      if (m_last && q.size() == 0) m_last = 1'b0;
      step();
      cyc++;
    end
    chk("rand.words_taken", idx, N_WORDS);
    chk("rand.in_budget", int'(cyc < MAX_CYC), 1);
    drive(0,0,0,0,8'h00,0);
    step();
    chk_all("rand.end", 8'h00, 0, 0, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
